// File: rtl/washer_actuator_monitor.sv
// Plant model and safety monitor for the washer controller's actuator commands:
// tracks water level and drum speed, latches the first unsafe pattern seen, counts cycles.
module washer_actuator_monitor #(
   parameter int unsigned LVL_W      = 8,
   parameter int unsigned LVL_MAX    = 200,
   parameter int unsigned FILL_STEP  = 20,
   parameter int unsigned DRAIN_STEP = 25,
   parameter int unsigned SPD_W      = 4,
   parameter int unsigned SPD_MAX    = 15,
   parameter int unsigned WDOG       = 31
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fill_valve,
   input  logic             motor,
   input  logic             drain_valve,
   input  logic             soap_dispenser,
   input  logic             done,
   input  logic [2:0]       state,
   input  logic             fault_clr,
   output logic [LVL_W-1:0] water_level,
   output logic             tank_full,
   output logic             tank_empty,
   output logic [SPD_W-1:0] drum_speed,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic             interlock,
   output logic [7:0]       cycle_count
);

   localparam int unsigned LX_W = LVL_W + 1;
   localparam int unsigned WD_W = $clog2(WDOG + 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WASH = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_FILL_DRN = 3'd1;
   localparam logic [2:0] FC_DRY_WASH = 3'd2;
   localparam logic [2:0] FC_OVERFLOW = 3'd3;
   localparam logic [2:0] FC_WATCHDOG = 3'd4;
   localparam logic [2:0] FC_ILLEGAL  = 3'd5;

   typedef enum logic [1:0] {
      M_IDLE  = 2'd0,
      M_RUN   = 2'd1,
      M_FAULT = 2'd2
   } mon_state_e;

   mon_state_e       mstate_q, mstate_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic [SPD_W-1:0] speed_q, speed_d;
   logic             fault_q, fault_d;
   logic             interlock_q, interlock_d;
   logic [2:0]       fault_code_q, fault_code_d;
   logic [7:0]       cycle_count_q, cycle_count_d;
   logic [WD_W-1:0]  wdog_q, wdog_d;
   logic [2:0]       prev_state_q, prev_state_d;
   logic             done_q, done_d;

   logic [LX_W-1:0]  lvl_ext_c;
   logic [LX_W-1:0]  lvl_sum_c;
   logic [2:0]       cond_code_c;
   logic             cond_any_c;
   logic             unused_soap_c;

   // Soap dispensing has no plant effect and no safety rule attached.
   assign unused_soap_c = soap_dispenser;

   // Water level: widened arithmetic so neither direction can wrap.
   always_comb begin
      lvl_ext_c = {1'b0, level_q};
      lvl_sum_c = lvl_ext_c + LX_W'(FILL_STEP);
      level_d   = level_q;
      if (fill_valve && !drain_valve) begin
         level_d = (lvl_sum_c > LX_W'(LVL_MAX)) ? LVL_W'(LVL_MAX) : lvl_sum_c[LVL_W-1:0];
      end else if (drain_valve && !fill_valve) begin
         level_d = (lvl_ext_c < LX_W'(DRAIN_STEP)) ? '0
                                                    : LVL_W'(lvl_ext_c - LX_W'(DRAIN_STEP));
      end
      full_d  = (level_d == LVL_W'(LVL_MAX));
      empty_d = (level_d == '0);
   end

   // Drum speed ramps one step per clock toward SPD_MAX or zero.
   always_comb begin
      speed_d = speed_q;
      if (motor && speed_q != SPD_W'(SPD_MAX)) begin
         speed_d = speed_q + SPD_W'(1);
      end else if (!motor && speed_q != '0) begin
         speed_d = speed_q - SPD_W'(1);
      end
   end

   // Watchdog measures how long a single active state has been held.
   always_comb begin
      prev_state_d = state;
      done_d       = done;
      if (state != prev_state_q || state == ST_IDLE || state == ST_DONE) begin
         wdog_d = '0;
      end else if (wdog_q == WD_W'(WDOG)) begin
         wdog_d = wdog_q;
      end else begin
         wdog_d = wdog_q + WD_W'(1);
      end
   end

   // Fault conditions in priority order; the lowest code wins.
   always_comb begin
      cond_code_c = FC_NONE;
      if (fill_valve && drain_valve) begin
         cond_code_c = FC_FILL_DRN;
      end else if (motor && state == ST_WASH && level_q == '0) begin
         cond_code_c = FC_DRY_WASH;
      end else if (fill_valve && full_q) begin
         cond_code_c = FC_OVERFLOW;
      end else if (wdog_q == WD_W'(WDOG)) begin
         cond_code_c = FC_WATCHDOG;
      end else if (state[2] && state[1] || (done && state != ST_DONE)) begin
         cond_code_c = FC_ILLEGAL;
      end
      cond_any_c = (cond_code_c != FC_NONE);
   end

   // Monitor FSM: next state and latched fault code.
   always_comb begin
      mstate_d     = mstate_q;
      fault_code_d = fault_code_q;
      unique case (mstate_q)
         M_IDLE: begin
            if (cond_any_c) begin
               mstate_d     = M_FAULT;
               fault_code_d = cond_code_c;
            end else if (state != ST_IDLE) begin
               mstate_d = M_RUN;
            end
         end
         M_RUN: begin
            if (cond_any_c) begin
               mstate_d     = M_FAULT;
               fault_code_d = cond_code_c;
            end else if (state == ST_IDLE) begin
               mstate_d = M_IDLE;
            end
         end
         M_FAULT: begin
            if (fault_clr && !cond_any_c) begin
               mstate_d     = M_IDLE;
               fault_code_d = FC_NONE;
            end
         end
         default: begin
            mstate_d     = M_IDLE;
            fault_code_d = FC_NONE;
         end
      endcase
      fault_d     = (mstate_d == M_FAULT);
      interlock_d = (mstate_d == M_FAULT);
   end

   // Completed cycles: rising edge of done while running.
   always_comb begin
      cycle_count_d = cycle_count_q;
      if (done && !done_q && mstate_q == M_RUN && cycle_count_q != 8'hFF) begin
         cycle_count_d = cycle_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mstate_q      <= M_IDLE;
         level_q       <= '0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         speed_q       <= '0;
         fault_q       <= 1'b0;
         interlock_q   <= 1'b0;
         fault_code_q  <= FC_NONE;
         cycle_count_q <= '0;
         wdog_q        <= '0;
         prev_state_q  <= ST_IDLE;
         done_q        <= 1'b0;
      end else begin
         mstate_q      <= mstate_d;
         level_q       <= level_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         speed_q       <= speed_d;
         fault_q       <= fault_d;
         interlock_q   <= interlock_d;
         fault_code_q  <= fault_code_d;
         cycle_count_q <= cycle_count_d;
         wdog_q        <= wdog_d;
         prev_state_q  <= prev_state_d;
         done_q        <= done_d;
      end
   end

   assign water_level = level_q;
   assign tank_full   = full_q;
   assign tank_empty  = empty_q;
   assign drum_speed  = speed_q;
   assign fault       = fault_q;
   assign fault_code  = fault_code_q;
   assign interlock   = interlock_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_washer_actuator_monitor.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each clock.
module tb_washer_actuator_monitor;

   localparam int LVL_MAX    = 200;
   localparam int FILL_STEP  = 20;
   localparam int DRAIN_STEP = 25;
   localparam int SPD_MAX    = 15;
   localparam int WDOG       = 31;

   logic       clk = 1'b0;
   logic       reset;
   logic       fill_valve, motor, drain_valve, soap_dispenser, done, fault_clr;
   logic [2:0] state;
   logic [7:0] water_level;
   logic       tank_full, tank_empty, fault, interlock;
   logic [3:0] drum_speed;
   logic [2:0] fault_code;
   logic [7:0] cycle_count;

   washer_actuator_monitor dut (
      .clk(clk), .reset(reset), .fill_valve(fill_valve), .motor(motor),
      .drain_valve(drain_valve), .soap_dispenser(soap_dispenser), .done(done),
      .state(state), .fault_clr(fault_clr), .water_level(water_level),
      .tank_full(tank_full), .tank_empty(tank_empty), .drum_speed(drum_speed),
      .fault(fault), .fault_code(fault_code), .interlock(interlock),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lvl; int spd; int flt; int code; int cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   // Reference model: plain integer bookkeeping of the plant and safety rules.
   int m_lvl, m_spd, m_cnt, m_code, m_run_len, m_prev_st;
   bit m_in_fault, m_running, m_prev_done;

   function automatic void model_reset();
      m_lvl = 0; m_spd = 0; m_cnt = 0; m_code = 0; m_run_len = 0; m_prev_st = 0;
      m_in_fault = 0; m_running = 0; m_prev_done = 0;
   endfunction

   function automatic exp_t model_step(bit f, bit m, bit d, bit dn, int st, bit clr);
      int   c;
      exp_t e;
      c = 0;
      if (f && d)                                 c = 1;
      else if (m && st == 2 && m_lvl == 0)         c = 2;
      else if (f && m_lvl == LVL_MAX)              c = 3;
      else if (m_run_len == WDOG)                  c = 4;
      else if (st >= 6 || (dn && st != 5))         c = 5;
      if (!m_in_fault && m_running && dn && !m_prev_done && m_cnt < 255) m_cnt++;
      if (m_in_fault) begin
         if (clr && c == 0) begin m_in_fault = 0; m_code = 0; m_running = 0; end
      end else if (c != 0) begin
         m_in_fault = 1; m_code = c;
      end else begin
         m_running = (st != 0);
      end
      if (f && !d)      m_lvl = (m_lvl + FILL_STEP > LVL_MAX) ? LVL_MAX : m_lvl + FILL_STEP;
      else if (d && !f) m_lvl = (m_lvl < DRAIN_STEP) ? 0 : m_lvl - DRAIN_STEP;
      if (m) m_spd = (m_spd < SPD_MAX) ? m_spd + 1 : SPD_MAX;
      else   m_spd = (m_spd > 0) ? m_spd - 1 : 0;
      if (st != m_prev_st || st == 0 || st == 5) m_run_len = 0;
      else if (m_run_len < WDOG)                 m_run_len++;
      m_prev_st = st; m_prev_done = dn;
      e.lvl = m_lvl; e.spd = m_spd; e.flt = int'(m_in_fault); e.code = m_code; e.cnt = m_cnt;
      return e;
   endfunction

   function automatic bit outputs_match(exp_t e);
      return int'(water_level) == e.lvl && tank_full == (e.lvl == LVL_MAX) &&
             tank_empty == (e.lvl == 0) && int'(drum_speed) == e.spd &&
             int'(fault) == e.flt && int'(interlock) == e.flt &&
             int'(fault_code) == e.code && int'(cycle_count) == e.cnt;
   endfunction

   task automatic report(string name, exp_t e);
      $display("FAIL %s @%0t: got lvl=%0d full=%0b empty=%0b spd=%0d fault=%0b il=%0b code=%0d cnt=%0d; want lvl=%0d spd=%0d fault=%0d code=%0d cnt=%0d",
               name, $time, water_level, tank_full, tank_empty, drum_speed, fault, interlock,
               fault_code, cycle_count, e.lvl, e.spd, e.flt, e.code, e.cnt);
   endtask

   // Monitor: outputs update every clock, so one prediction is consumed per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (!outputs_match(e)) begin
               n_fails++;
               report("outputs", e);
            end
         end
      end
   end

   task automatic step(bit f, bit m, bit d, bit dn, int st, bit clr);
      @(negedge clk);
      fill_valve = f; motor = m; drain_valve = d; done = dn;
      state = 3'(st); fault_clr = clr; soap_dispenser = 1'($urandom_range(0, 1));
      q.push_back(model_step(f, m, d, dn, st, clr));
   endtask

   task automatic quiet(int n);
      repeat (n) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge clk);
      reset = 1'b1;
      fill_valve = 0; motor = 0; drain_valve = 0; done = 0; state = 3'd0; fault_clr = 0;
      #1;
      model_reset();
      e.lvl = 0; e.spd = 0; e.flt = 0; e.code = 0; e.cnt = 0;
      n_checks++;
      if (!outputs_match(e)) begin
         n_fails++;
         report("reset", e);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int st;
      int guard;
      reset = 1'b1;
      fill_valve = 0; motor = 0; drain_valve = 0; soap_dispenser = 0;
      done = 0; state = 3'd0; fault_clr = 0;
      model_reset();
      do_reset();

      // Fill to saturation, then overflow on the first fill at full.
      repeat (12) step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      // Drain to empty and hold.
      repeat (10) step(0, 0, 1, 0, 0, 0);
      // Fill and drain together, then clear.
      step(1, 0, 1, 0, 0, 0);
      quiet(1);
      step(0, 0, 0, 0, 0, 1);
      quiet(1);
      // Dry wash; with an illegal done in the same clock the lower code wins.
      step(0, 1, 0, 0, 2, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 1, 2, 0);
      step(0, 0, 0, 0, 0, 1);
      quiet(2);
      // Watchdog on a held state, none when states alternate.
      repeat (WDOG + 4) step(0, 0, 0, 0, 3, 0);
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) repeat (10) step(0, 0, 0, 0, (i % 2 == 0) ? 3 : 4, 0);
      quiet(2);
      // Three legal cycles with a done pulse each.
      for (int c = 0; c < 3; c++) begin
         repeat (3) step(1, 0, 0, 0, 1, 0);
         repeat (3) step(0, 1, 0, 0, 2, 0);
         repeat (3) step(0, 1, 0, 0, 3, 0);
         repeat (3) step(0, 1, 1, 0, 4, 0);
         step(0, 0, 0, 1, 5, 0);
         step(0, 0, 0, 0, 5, 0);
         quiet(1);
      end
      // Done outside the DONE state, then reset in the middle of a fill.
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      quiet(1);
      repeat (3) step(1, 0, 0, 0, 1, 0);
      do_reset();

      // Randomized phase with a mostly-legal state walk.
      st = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) st = $urandom_range(0, 5);
         if ($urandom_range(0, 63) == 0) st = $urandom_range(6, 7);
         step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
              st, 1'($urandom_range(0, 7) == 0));
         if (st > 5) st = 0;
         if (i % 150 == 149) do_reset();
      end

      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (q.size() > 0) begin
         n_fails++;
         $display("FAIL drain: %0d predictions left unchecked, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
